// File: rtl/event_indicator_pkg.sv
// Shared types and helpers for the event indicator LED feedback stage.
package event_indicator_pkg;

    typedef enum logic [1:0] {IDLE, ON, OFF} ind_state_t;

    // Bits needed to hold n-1, never less than one so a 1-cycle phase still has a counter.
    function automatic int width_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             enable,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (enable && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/event_indicator.sv
// Turns single-cycle event pulses into LED blink sequences, queueing events that
// arrive while a sequence is running and replaying them back-to-back.
module event_indicator
    import event_indicator_pkg::*;
#(
    parameter int ON_CYCLES   = 25_000_000,
    parameter int OFF_CYCLES  = 25_000_000,
    parameter int BLINKS      = 2,
    parameter int MAX_PENDING = 3,
    localparam int PW         = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in,
    output logic          out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          dropped
);

    localparam int TW = (width_for(ON_CYCLES) > width_for(OFF_CYCLES)) ?
                        width_for(ON_CYCLES) : width_for(OFF_CYCLES);
    localparam int BW = $clog2(BLINKS + 1);

    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [BW-1:0] BLINKS_V = BW'(BLINKS);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    ind_state_t      state, next_state;
    logic [BW-1:0]   blink_cnt, next_blink;
    logic [PW-1:0]   next_pending;
    logic            next_dropped;
    logic            timer_load;
    logic [TW-1:0]   timer_value;
    logic            timer_done;
    logic            seq_done;

    cycle_timer #(.WIDTH(TW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .value  (timer_value),
        .enable (state != IDLE),
        .done   (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            blink_cnt <= '0;
            pending   <= '0;
            dropped   <= 1'b0;
            out       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            blink_cnt <= next_blink;
            pending   <= next_pending;
            dropped   <= next_dropped;
            out       <= (next_state == ON);
            busy      <= (next_state != IDLE);
        end
    end

    assign seq_done = (state == OFF) && timer_done && (blink_cnt >= BLINKS_V);

    always_comb begin
        next_state   = state;
        next_blink   = blink_cnt;
        next_pending = pending;
        next_dropped = 1'b0;
        timer_load   = 1'b0;
        timer_value  = ON_LOAD;

        case (state)
            IDLE: begin
                if (in) begin
                    next_state = ON;
                    next_blink = BW'(1);
                    timer_load = 1'b1;
                end
            end
            ON: begin
                if (timer_done) begin
                    next_state  = OFF;
                    timer_load  = 1'b1;
                    timer_value = OFF_LOAD;
                end
            end
            OFF: begin
                if (timer_done) begin
                    if (blink_cnt < BLINKS_V) begin
                        next_state = ON;
                        next_blink = blink_cnt + BW'(1);
                        timer_load = 1'b1;
                    // A queued event or one arriving right now restarts with no idle gap.
                    end else if (pending != '0 || in) begin
                        next_state = ON;
                        next_blink = BW'(1);
                        timer_load = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase

        // An event on the completion edge either cancels the dequeue or starts the next run.
        if (state != IDLE) begin
            if (seq_done) begin
                if (pending != '0 && !in) begin
                    next_pending = pending - PW'(1);
                end
            end else if (in) begin
                if (pending == PEND_MAX) begin
                    next_dropped = 1'b1;
                end else begin
                    next_pending = pending + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_event_indicator.sv
// Scoreboard bench for event_indicator: a position-in-sequence reference model feeds
// an expectation queue that a negedge monitor drains against the DUT outputs.
module tb_event_indicator;

    localparam int ON_C    = 4;
    localparam int OFF_C   = 4;
    localparam int BL      = 2;
    localparam int MAXP    = 3;
    localparam int PW      = $clog2(MAXP + 1);
    localparam int SEQ_LEN = BL * (ON_C + OFF_C);

    logic          clk = 1'b0;
    logic          reset;
    logic          pulse;
    logic          out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          dropped;

    always #5 clk = ~clk;

    event_indicator #(
        .ON_CYCLES   (ON_C),
        .OFF_CYCLES  (OFF_C),
        .BLINKS      (BL),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (pulse),
        .out     (out),
        .busy    (busy),
        .pending (pending),
        .dropped (dropped)
    );

    typedef struct {
        logic out;
        logic busy;
        int   pend;
        logic dropped;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests    = 0;
    int   failures = 0;
    int   cycle    = 0;

    // Reference state: whether a sequence runs, where in it we are, and queued events.
    bit   m_active = 1'b0;
    int   m_pos    = 0;
    int   m_pend   = 0;
    bit   m_drop   = 1'b0;

    function automatic void modelStep(input logic in_v, input logic rst_v);
        if (rst_v) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_pend   = 0;
            m_drop   = 1'b0;
        end else begin
            m_drop = 1'b0;
            if (!m_active) begin
                if (in_v) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                end
            end else if (m_pos == SEQ_LEN - 1) begin
                if (m_pend > 0 || in_v) begin
                    m_pos = 0;
                    if (!in_v) m_pend--;
                end else begin
                    m_active = 1'b0;
                    m_pos    = 0;
                end
            end else begin
                m_pos++;
                if (in_v) begin
                    if (m_pend == MAXP) m_drop = 1'b1;
                    else m_pend++;
                end
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] want, input int cyc);
        tests++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    task automatic applyStimulus(input logic in_v, input logic rst_v);
        exp_t e;
        pulse = in_v;
        reset = rst_v;
        @(posedge clk);
        modelStep(in_v, rst_v);
        e.out     = m_active && ((m_pos % (ON_C + OFF_C)) < ON_C);
        e.busy    = m_active;
        e.pend    = m_pend;
        e.dropped = m_drop;
        e.cyc     = cycle;
        exp_q.push_back(e);
        cycle++;
        #1;
    endtask

    task automatic runPattern(input logic [127:0] ins, input logic [127:0] rsts, input int len);
        for (int i = 0; i < len; i++) begin
            applyStimulus(ins[i], rsts[i]);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("out",     32'(out),     32'(e.out),     e.cyc);
                checkOutput("busy",    32'(busy),    32'(e.busy),    e.cyc);
                checkOutput("pending", 32'(pending), 32'(e.pend),    e.cyc);
                checkOutput("dropped", 32'(dropped), 32'(e.dropped), e.cyc);
            end
        end
    end

    initial begin : stimulus
        int guard;
        pulse = 1'b0;
        reset = 1'b1;

        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        runPattern('0, '0, 3);

        // Single pulse: one full sequence then idle.
        runPattern(128'h1, '0, 20);

        // Second pulse queued mid-sequence, replayed without a gap.
        runPattern((128'(1) << 0) | (128'(1) << 5), '0, 36);

        // Five pulses: queue saturates at three, the fifth is dropped.
        runPattern(128'h5D, '0, 70);

        // Pulse on the completion edge while one event is queued.
        runPattern((128'(1) << 0) | (128'(1) << 5) | (128'(1) << 16), '0, 52);

        // Reset mid-sequence with two queued, then a clean restart.
        runPattern((128'(1) << 0) | (128'(1) << 2) | (128'(1) << 3) | (128'(1) << 10),
                   (128'(1) << 6), 30);

        // Randomized traffic including occasional held-high bursts and resets.
        for (int i = 0; i < 3000; i++) begin
            logic in_v;
            logic rst_v;
            in_v  = ($urandom_range(0, 4) == 0) || ((i % 200) < 6 && (i % 200) > 2);
            rst_v = ($urandom_range(0, 299) == 0);
            applyStimulus(in_v, rst_v);
        end

        pulse = 1'b0;
        reset = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d queued expectations, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
